// File: rtl/stopwatch_game_ctrl.sv
// stopwatch_game_ctrl: prescaled LED-strip counter with hit/miss judging, score, lives and win/lose sequencing
module stopwatch_game_ctrl #(
  parameter int LED_NUM    = 10,
  parameter int CNT_LIM    = 100,
  parameter int TICK_DIV   = 500000,
  parameter int LIVES      = 3,
  parameter int HOLD_TICKS = 20
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  output logic [$clog2(CNT_LIM):0]       cnt_o,
  output logic [LED_NUM-1:0]             sw_o,
  output logic [$clog2(LED_NUM+1)-1:0]   score_o,
  output logic [$clog2(LIVES+1)-1:0]     lives_o,
  output logic                           run_o,
  output logic                           win_o,
  output logic                           lose_o
);
  localparam int CW    = $clog2(CNT_LIM) + 1;
  localparam int SW    = $clog2(LED_NUM + 1);
  localparam int LW    = $clog2(LIVES + 1);
  localparam int PW    = $clog2(TICK_DIV);
  localparam int HW    = $clog2(HOLD_TICKS + 1);
  localparam int IW    = $clog2(LED_NUM);
  localparam int DELTA = CNT_LIM / LED_NUM;
  typedef enum logic [2:0] {IDLE, RUN, HOLD, WIN, LOSE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [HW-1:0] hold, hold_n;
  logic [CW-1:0] cnt_n, q;
  logic [LED_NUM-1:0] sw_n, clr;
  logic [SW-1:0] score_n;
  logic [LW-1:0] lives_n;
  logic [IW-1:0] idx;
  logic tc;
  // strip lights LED 0 for the first segment, then walks down from the top LED
  assign q      = cnt_o / CW'(DELTA);
  assign idx    = IW'((q == '0) ? CW'(0) : CW'(LED_NUM) - q);
  assign clr    = sw_o & ~(LED_NUM'(1) << idx);
  assign tc     = pre == PW'(TICK_DIV - 1);
  assign run_o  = (state == RUN) || (state == HOLD);
  assign win_o  = state == WIN;
  assign lose_o = state == LOSE;
  always_comb begin
    state_n = state;
    pre_n   = pre;
    hold_n  = hold;
    cnt_n   = cnt_o;
    sw_n    = sw_o;
    score_n = score_o;
    lives_n = lives_o;
    case (state)
      RUN: begin
        pre_n = tc ? '0 : pre + PW'(1);
        cnt_n = !tc ? cnt_o : (cnt_o == CW'(CNT_LIM - 1)) ? '0 : cnt_o + CW'(1);
        if (stop_i) begin
          // a press discards any coincident tick so the hold starts on a clean prescaler
          pre_n   = '0;
          hold_n  = '0;
          cnt_n   = cnt_o;
          sw_n    = sw_o[idx] ? clr : sw_o;
          score_n = sw_o[idx] ? score_o + SW'(1) : score_o;
          lives_n = sw_o[idx] ? lives_o : lives_o - LW'(1);
          state_n = sw_o[idx] ? ((clr == '0) ? WIN : HOLD) : ((lives_o == LW'(1)) ? LOSE : HOLD);
        end
      end
      HOLD: begin
        pre_n   = tc ? '0 : pre + PW'(1);
        hold_n  = tc ? hold + HW'(1) : hold;
        state_n = (tc && hold == HW'(HOLD_TICKS - 1)) ? RUN : HOLD;
      end
      default: begin
        if (start_i) begin
          state_n = RUN;
          pre_n   = '0;
          hold_n  = '0;
          cnt_n   = '0;
          sw_n    = '1;
          score_n = '0;
          lives_n = LW'(LIVES);
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pre     <= '0;
      hold    <= '0;
      cnt_o   <= '0;
      sw_o    <= '1;
      score_o <= '0;
      lives_o <= LW'(LIVES);
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      hold    <= hold_n;
      cnt_o   <= cnt_n;
      sw_o    <= sw_n;
      score_o <= score_n;
      lives_o <= lives_n;
    end
  end
endmodule

// File: tb/tb_stopwatch_game_ctrl.sv
// tb_stopwatch_game_ctrl: directed table, corner sequences and random stimulus against a time-based game model
module tb_stopwatch_game_ctrl;
  localparam int LN = 10, CL = 100, TD = 2, LV = 3, HT = 2;
  logic clk, rst_i, start_i, stop_i;
  logic [7:0] cnt_o;
  logic [9:0] sw_o;
  logic [3:0] score_o;
  logic [1:0] lives_o;
  logic run_o, win_o, lose_o;
  int checks = 0, failures = 0;

  stopwatch_game_ctrl #(.LED_NUM(LN), .CNT_LIM(CL), .TICK_DIV(TD), .LIVES(LV), .HOLD_TICKS(HT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .cnt_o(cnt_o), .sw_o(sw_o),
    .score_o(score_o), .lives_o(lives_o), .run_o(run_o), .win_o(win_o), .lose_o(lose_o));

  initial clk = 0;
  always #5 clk = ~clk;

  // model phases: 0 idle, 1 run, 2 hold, 3 win, 4 lose; run count derived from elapsed cycles
  int ph, base, el, hrem, score, lives;
  logic [9:0] lit;

  function automatic int mcnt();
    return (ph == 1) ? (base + el / TD) % CL : base;
  endfunction

  function automatic int lidx(input int c);
    int q;
    q = c / (CL / LN);
    return (q == 0) ? 0 : LN - q;
  endfunction

  task automatic m_reset();
    ph = 0; base = 0; el = 0; hrem = 0; score = 0; lives = LV; lit = '1;
  endtask

  task automatic m_step(input bit st, input bit sp);
    int c, i;
    c = mcnt();
    case (ph)
      1: if (sp) begin
        i = lidx(c);
        base = c; el = 0; hrem = HT * TD;
        if (lit[i]) begin
          lit[i] = 1'b0; score++;
          ph = (lit == 0) ? 3 : 2;
        end else begin
          lives--;
          ph = (lives == 0) ? 4 : 2;
        end
      end else el++;
      2: begin
        hrem--;
        if (hrem == 0) begin ph = 1; el = 0; end
      end
      default: if (st) begin
        ph = 1; base = 0; el = 0; lit = '1; score = 0; lives = LV;
      end
    endcase
  endtask

  task automatic chk(input string nm, input int c, input logic [9:0] w, input int s, input int l,
                     input bit r, input bit wi, input bit lo);
    checks++;
    if (cnt_o !== 8'(c) || sw_o !== w || score_o !== 4'(s) || lives_o !== 2'(l) ||
        run_o !== r || win_o !== wi || lose_o !== lo) begin
      failures++;
      $display("FAIL %s @%0t: got cnt=%0d sw=%h score=%0d lives=%0d rwl=%b%b%b, expected cnt=%0d sw=%h score=%0d lives=%0d rwl=%b%b%b",
               nm, $time, cnt_o, sw_o, score_o, lives_o, run_o, win_o, lose_o, c, w, s, l, r, wi, lo);
    end
  endtask

  task automatic cyc(input bit st, input bit sp);
    start_i = st; stop_i = sp;
    m_step(st, sp);
    @(posedge clk); #1;
    chk("model", mcnt(), lit, score, lives, ph == 1 || ph == 2, ph == 3, ph == 4);
  endtask

  task automatic do_reset();
    start_i = 0; stop_i = 0; rst_i = 1; m_reset();
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  typedef struct {
    bit st, sp; int n; int c; logic [9:0] w; int s, l; bit r, wi, lo;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit st, input bit sp, input int n, input int c, input logic [9:0] w,
                     input int s, input int l, input bit r, input bit wi, input bit lo);
    vec_t v;
    v.st = st; v.sp = sp; v.n = n; v.c = c; v.w = w; v.s = s; v.l = l; v.r = r; v.wi = wi; v.lo = lo;
    tbl.push_back(v);
  endtask

  initial begin
    bit found;
    add(1, 0, 1,   0,  10'h3FF, 0, 3, 1, 0, 0);
    add(0, 0, 10,  5,  10'h3FF, 0, 3, 1, 0, 0);
    add(0, 1, 1,   5,  10'h3FE, 1, 3, 1, 0, 0);
    add(0, 1, 3,   5,  10'h3FE, 1, 3, 1, 0, 0);
    add(0, 0, 1,   5,  10'h3FE, 1, 3, 1, 0, 0);
    add(1, 0, 2,   6,  10'h3FE, 1, 3, 1, 0, 0);
    add(0, 1, 1,   6,  10'h3FE, 1, 2, 1, 0, 0);
    add(0, 0, 4,   6,  10'h3FE, 1, 2, 1, 0, 0);
    add(0, 1, 1,   6,  10'h3FE, 1, 1, 1, 0, 0);
    add(0, 0, 4,   6,  10'h3FE, 1, 1, 1, 0, 0);
    add(0, 1, 1,   6,  10'h3FE, 1, 0, 0, 0, 1);
    add(0, 1, 3,   6,  10'h3FE, 1, 0, 0, 0, 1);
    add(1, 0, 1,   0,  10'h3FF, 0, 3, 1, 0, 0);
    add(0, 0, 39,  19, 10'h3FF, 0, 3, 1, 0, 0);
    add(0, 1, 1,   19, 10'h1FF, 1, 3, 1, 0, 0);
    add(0, 0, 4,   19, 10'h1FF, 1, 3, 1, 0, 0);
    add(0, 0, 2,   20, 10'h1FF, 1, 3, 1, 0, 0);
    add(0, 0, 158, 99, 10'h1FF, 1, 3, 1, 0, 0);
    add(0, 0, 2,   0,  10'h1FF, 1, 3, 1, 0, 0);
    add(0, 0, 2,   1,  10'h1FF, 1, 3, 1, 0, 0);
    add(0, 0, 184, 93, 10'h1FF, 1, 3, 1, 0, 0);
    add(0, 1, 1,   93, 10'h1FD, 2, 3, 1, 0, 0);
    add(0, 0, 4,   93, 10'h1FD, 2, 3, 1, 0, 0);
    add(0, 0, 4,   95, 10'h1FD, 2, 3, 1, 0, 0);
    add(0, 1, 1,   95, 10'h1FD, 2, 2, 1, 0, 0);

    rst_i = 1; start_i = 0; stop_i = 0; m_reset();
    @(posedge clk); #1;
    chk("reset", 0, 10'h3FF, 0, 3, 0, 0, 0);
    rst_i = 0;
    cyc(0, 1);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].st, tbl[i].sp);
      chk($sformatf("vec%0d", i), tbl[i].c, tbl[i].w, tbl[i].s, tbl[i].l, tbl[i].r, tbl[i].wi, tbl[i].lo);
    end

    for (int k = 0; k < 3000; k++) cyc($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);

    do_reset();
    cyc(1, 0);
    for (int led = 0; led < LN; led++) begin
      found = 0;
      for (int k = 0; k < 400 && !found; k++) begin
        if (ph == 1 && lidx(mcnt()) == led) begin cyc(0, 1); found = 1; end
        else cyc(0, 0);
      end
      if (!found) begin
        checks++; failures++;
        $display("FAIL win_seek: led %0d never reached, expected reachable within 400 cycles", led);
      end
    end
    chk("win", mcnt(), 10'h000, 10, 3, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1);
    chk("win_frozen", mcnt(), 10'h000, 10, 3, 0, 1, 0);

    cyc(1, 0);
    chk("restart", 0, 10'h3FF, 0, 3, 1, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0);
    cyc(0, 1);
    cyc(0, 0);
    chk("pre_rst_hold", 3, 10'h3FE, 1, 3, 1, 0, 0);
    #2 rst_i = 1;
    #1 chk("rst_async", 0, 10'h3FF, 0, 3, 0, 0, 0);
    m_reset();
    @(posedge clk); #1;
    rst_i = 0;
    cyc(0, 0);
    cyc(1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
